pipe_ctrl_unit: RTL and testbench
=================================

# pipe_ctrl_unit

Pipelined control unit for the 5-stage RV32I core. Decodes the 5-bit major opcode (inst[6:2]) in ID and carries the control bits through ID/EX, EX/MEM and MEM/WB registers. Detects load-use hazards and applies branch/jump flushes. Optionally latches a sticky halt on SYSTEM instructions. Register address and opcode widths are parametrised.

## Interface
- OPW, 5, opcode field width
- RAW, 5, register address width
- ALUOPW, 2, ALUOp width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous and active-high
- id_valid  in  1  ID stage holds a real instruction
- id_opcode  in  OPW  inst[6:2] of ID instruction
- id_rs1, id_rs2, id_rd  in  RAW  ID register fields
- ex_flush  in  1  branch taken / jump resolved in EX this cycle
- stall  out  1  load-use stall; core holds PC and IF/ID
- ex_branch, ex_mem_read, ex_mem_to_reg, ex_mem_write, ex_alu_src, ex_reg_write, ex_jal, ex_jalr  out  1 each  ID/EX control bits
- ex_alu_op  out  ALUOPW  ID/EX ALUOp
- ex_rd  out  RAW  ID/EX destination
- mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_reg_write  out  1 each  EX/MEM control
- mem_rd  out  RAW
- wb_mem_to_reg, wb_reg_write  out  1 each  MEM/WB control
- wb_rd  out  RAW
- halt  out  1  sticky halt (CTRL_HALT_EN only; tied 0 otherwise)

## Operation
- Decode, by opcode. Every bit not listed is 0.
  - 01100 R: reg_write, alu_op=10.
  - 00100 I-ALU: alu_src, reg_write, alu_op=11.
  - 00000 LOAD: mem_read, mem_to_reg, alu_src, reg_write, alu_op=00.
  - 01000 STORE: mem_write, alu_src, alu_op=00.
  - 11000 BRANCH: branch, alu_op=01.
  - 11011 JAL: jal, reg_write.
  - 11001 JALR: jalr, alu_src, reg_write.
  - 01101 LUI and 00101 AUIPC: alu_src, reg_write, alu_op=00.
  - 11100 SYSTEM: sys flag only.
  - Any other opcode: all zero (bubble).
- reg_write is forced 0 when id_rd==0.
- Bubble rule: when id_valid=0 the decode output is all zero.
- Load-use stall (combinational): stall = id_valid & ex_mem_read & (ex_rd!=0) & (ex_rd==id_rs1 | ex_rd==id_rs2).
- When stall=1, ID/EX loads a bubble. EX/MEM and MEM/WB advance normally.
- Flush: ex_flush=1 makes ID/EX load a bubble at the next edge. The EX instruction itself advances to MEM.
- Flush has priority over stall. When both are asserted, stall is still output but has no additional effect.
- No global freeze. EX/MEM and MEM/WB advance every cycle.

## Timing
- Reset: every pipeline control bit, every rd register and halt = 0. stall = 0 because ex_mem_read = 0.
- Latency from ID presentation to outputs: ex_* at edge+1, mem_* at +2, wb_* at +3.
- stall is valid in the same cycle as the ID inputs and ex_* registers that produce it.
- rst asserted mid-operation clears all stages at that edge. In-flight instructions are lost.

## Configuration
- CTRL_HALT_EN defined:
  - SYSTEM carries a sys bit through all stages.
  - halt sets at the edge where the sys bit enters MEM/WB and stays 1 until rst.
  - While halt=1, decode output is forced to bubble.
  - A flushed SYSTEM instruction never sets halt.
- CTRL_HALT_EN undefined: no sys pipeline bits, SYSTEM decodes as a bubble, halt = 0.

## Structure
- ctrl_pkg holds:
  - opcode localparams (OP_R, OP_IALU, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_SYSTEM);
  - ALUOp encodings (ALUOP_ADD=00, ALUOP_BR=01, ALUOP_R=10, ALUOP_I=11);
  - the ctrl_t packed struct of control bits.
- Sub-module ctrl_decode: purely combinational opcode→ctrl_t decoder, including the rd==0 rule.
- The top module holds the pipeline registers, hazard logic and halt latch.

## Test plan
- Reset then LW (00000, rd=5): ex_mem_read=1, ex_mem_to_reg=1, ex_alu_src=1, ex_reg_write=1 one cycle later; wb_reg_write=1 with wb_rd=5 at +3.
- LW rd=5, then ADD with rs2=5 in ID: stall=1 for exactly one cycle; ex_* is bubble (all 0) at the next edge; ADD decodes on the following cycle.
- LW rd=0, then ADD rs1=0: stall stays 0; reg_write stays 0 through WB.
- BEQ (11000) in EX, ex_flush=1, JAL (11011) in ID: ex_jal=0 next cycle; mem stage still carries the branch.
- ex_flush=1 and stall condition asserted together: ID/EX becomes bubble; stall=1 that cycle only.
- CTRL_HALT_EN: SYSTEM (11100) issued → halt=1 three edges later and stays 1; a following ADD produces ex_reg_write=0; rst clears halt.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared opcode, ALUOp and control-bundle definitions for the pipelined RV32I control unit.
package ctrl_pkg;

    localparam int unsigned OP_W    = 5;
    localparam int unsigned ALUOP_W = 2;

    // Major opcodes, inst[6:2]
    localparam logic [OP_W-1:0] OP_R      = 5'b01100;
    localparam logic [OP_W-1:0] OP_IALU   = 5'b00100;
    localparam logic [OP_W-1:0] OP_LOAD   = 5'b00000;
    localparam logic [OP_W-1:0] OP_STORE  = 5'b01000;
    localparam logic [OP_W-1:0] OP_BRANCH = 5'b11000;
    localparam logic [OP_W-1:0] OP_JAL    = 5'b11011;
    localparam logic [OP_W-1:0] OP_JALR   = 5'b11001;
    localparam logic [OP_W-1:0] OP_LUI    = 5'b01101;
    localparam logic [OP_W-1:0] OP_AUIPC  = 5'b00101;
    localparam logic [OP_W-1:0] OP_SYSTEM = 5'b11100;

    localparam logic [ALUOP_W-1:0] ALUOP_ADD = 2'b00;
    localparam logic [ALUOP_W-1:0] ALUOP_BR  = 2'b01;
    localparam logic [ALUOP_W-1:0] ALUOP_R   = 2'b10;
    localparam logic [ALUOP_W-1:0] ALUOP_I   = 2'b11;

    typedef struct packed {
        logic               sys;
        logic               branch;
        logic               mem_read;
        logic               mem_to_reg;
        logic               mem_write;
        logic               alu_src;
        logic               reg_write;
        logic               jal;
        logic               jalr;
        logic [ALUOP_W-1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/pipe_ctrl_unit_if.sv
// ID-side request and per-stage control outputs of the pipelined control unit.
interface pipe_ctrl_unit_if #(
    parameter int unsigned OPW    = 5,
    parameter int unsigned RAW    = 5,
    parameter int unsigned ALUOPW = 2
) ();

    logic              id_valid;
    logic [OPW-1:0]    id_opcode;
    logic [RAW-1:0]    id_rs1;
    logic [RAW-1:0]    id_rs2;
    logic [RAW-1:0]    id_rd;
    logic              ex_flush;

    logic              stall;
    logic              ex_branch;
    logic              ex_mem_read;
    logic              ex_mem_to_reg;
    logic              ex_mem_write;
    logic              ex_alu_src;
    logic              ex_reg_write;
    logic              ex_jal;
    logic              ex_jalr;
    logic [ALUOPW-1:0] ex_alu_op;
    logic [RAW-1:0]    ex_rd;
    logic              mem_mem_read;
    logic              mem_mem_write;
    logic              mem_mem_to_reg;
    logic              mem_reg_write;
    logic [RAW-1:0]    mem_rd;
    logic              wb_mem_to_reg;
    logic              wb_reg_write;
    logic [RAW-1:0]    wb_rd;
    logic              halt;

    modport master (
        output id_valid, id_opcode, id_rs1, id_rs2, id_rd, ex_flush,
        input  stall, ex_branch, ex_mem_read, ex_mem_to_reg, ex_mem_write,
               ex_alu_src, ex_reg_write, ex_jal, ex_jalr, ex_alu_op, ex_rd,
               mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_reg_write, mem_rd,
               wb_mem_to_reg, wb_reg_write, wb_rd, halt
    );

    modport slave (
        input  id_valid, id_opcode, id_rs1, id_rs2, id_rd, ex_flush,
        output stall, ex_branch, ex_mem_read, ex_mem_to_reg, ex_mem_write,
               ex_alu_src, ex_reg_write, ex_jal, ex_jalr, ex_alu_op, ex_rd,
               mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_reg_write, mem_rd,
               wb_mem_to_reg, wb_reg_write, wb_rd, halt
    );

endinterface

// File: rtl/ctrl_decode.sv
// Combinational opcode-to-control decoder. SYSTEM yields the sys bit only when CTRL_HALT_EN is defined.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int unsigned OPW = 5,
    parameter int unsigned RAW = 5
) (
    input  logic           valid,
    input  logic [OPW-1:0] opcode,
    input  logic [RAW-1:0] rd,
    output ctrl_t          ctrl_c
);

    always_comb begin
        ctrl_c = CTRL_BUBBLE;
        if (valid) begin
            case (opcode)
                OPW'(OP_R): begin
                    ctrl_c.reg_write = 1'b1;
                    ctrl_c.alu_op    = ALUOP_R;
                end
                OPW'(OP_IALU): begin
                    ctrl_c.alu_src   = 1'b1;
                    ctrl_c.reg_write = 1'b1;
                    ctrl_c.alu_op    = ALUOP_I;
                end
                OPW'(OP_LOAD): begin
                    ctrl_c.mem_read   = 1'b1;
                    ctrl_c.mem_to_reg = 1'b1;
                    ctrl_c.alu_src    = 1'b1;
                    ctrl_c.reg_write  = 1'b1;
                    ctrl_c.alu_op     = ALUOP_ADD;
                end
                OPW'(OP_STORE): begin
                    ctrl_c.mem_write = 1'b1;
                    ctrl_c.alu_src   = 1'b1;
                    ctrl_c.alu_op    = ALUOP_ADD;
                end
                OPW'(OP_BRANCH): begin
                    ctrl_c.branch = 1'b1;
                    ctrl_c.alu_op = ALUOP_BR;
                end
                OPW'(OP_JAL): begin
                    ctrl_c.jal       = 1'b1;
                    ctrl_c.reg_write = 1'b1;
                end
                OPW'(OP_JALR): begin
                    ctrl_c.jalr      = 1'b1;
                    ctrl_c.alu_src   = 1'b1;
                    ctrl_c.reg_write = 1'b1;
                end
                OPW'(OP_LUI), OPW'(OP_AUIPC): begin
                    ctrl_c.alu_src   = 1'b1;
                    ctrl_c.reg_write = 1'b1;
                    ctrl_c.alu_op    = ALUOP_ADD;
                end
`ifdef CTRL_HALT_EN
                OPW'(OP_SYSTEM): ctrl_c.sys = 1'b1;
`else
                OPW'(OP_SYSTEM): ctrl_c = CTRL_BUBBLE;
`endif
                default: ctrl_c = CTRL_BUBBLE;
            endcase
            // x0 is never written
            if (rd == '0) begin
                ctrl_c.reg_write = 1'b0;
            end
        end
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit: ID decode, ID/EX-EX/MEM-MEM/WB control registers, load-use stall, flush.
// Optional sticky halt on SYSTEM when CTRL_HALT_EN is defined.
module pipe_ctrl_unit
    import ctrl_pkg::*;
#(
    parameter int unsigned OPW    = 5,
    parameter int unsigned RAW    = 5,
    parameter int unsigned ALUOPW = 2
) (
    input  logic          clk,
    input  logic          rst,
    pipe_ctrl_unit_if.slave bus
);

    ctrl_t          id_ctrl;
    ctrl_t          ex_ctrl;
    logic [RAW-1:0] ex_rd_q;
    logic           mem_mem_read_q;
    logic           mem_mem_write_q;
    logic           mem_mem_to_reg_q;
    logic           mem_reg_write_q;
    logic [RAW-1:0] mem_rd_q;
    logic           wb_mem_to_reg_q;
    logic           wb_reg_write_q;
    logic [RAW-1:0] wb_rd_q;
    logic           halt_q;
    logic           dec_valid;
    logic           stall_c;
    logic           bubble_c;

`ifdef CTRL_HALT_EN
    logic           mem_sys_q;
    assign dec_valid = bus.id_valid & ~halt_q;
`else
    logic           sys_unused;
    assign dec_valid  = bus.id_valid;
    assign sys_unused = ex_ctrl.sys;
`endif

    ctrl_decode #(
        .OPW (OPW),
        .RAW (RAW)
    ) u_decode (
        .valid  (dec_valid),
        .opcode (bus.id_opcode),
        .rd     (bus.id_rd),
        .ctrl_c (id_ctrl)
    );

    // Load in EX whose destination feeds the ID instruction
    always_comb begin
        stall_c = bus.id_valid & ex_ctrl.mem_read & (ex_rd_q != '0) &
                  ((ex_rd_q == bus.id_rs1) | (ex_rd_q == bus.id_rs2));
        bubble_c = bus.ex_flush | stall_c | ~dec_valid;
    end

    // Pipeline registers; EX/MEM and MEM/WB never freeze
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_ctrl          <= CTRL_BUBBLE;
            ex_rd_q          <= '0;
            mem_mem_read_q   <= 1'b0;
            mem_mem_write_q  <= 1'b0;
            mem_mem_to_reg_q <= 1'b0;
            mem_reg_write_q  <= 1'b0;
            mem_rd_q         <= '0;
            wb_mem_to_reg_q  <= 1'b0;
            wb_reg_write_q   <= 1'b0;
            wb_rd_q          <= '0;
        end else begin
            ex_ctrl          <= bubble_c ? CTRL_BUBBLE : id_ctrl;
            ex_rd_q          <= bubble_c ? '0 : bus.id_rd;
            mem_mem_read_q   <= ex_ctrl.mem_read;
            mem_mem_write_q  <= ex_ctrl.mem_write;
            mem_mem_to_reg_q <= ex_ctrl.mem_to_reg;
            mem_reg_write_q  <= ex_ctrl.reg_write;
            mem_rd_q         <= ex_rd_q;
            wb_mem_to_reg_q  <= mem_mem_to_reg_q;
            wb_reg_write_q   <= mem_reg_write_q;
            wb_rd_q          <= mem_rd_q;
        end
    end

`ifdef CTRL_HALT_EN
    // The halt flag sets as the SYSTEM sys bit moves from EX/MEM into MEM/WB
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_sys_q <= 1'b0;
            halt_q    <= 1'b0;
        end else begin
            mem_sys_q <= ex_ctrl.sys;
            halt_q    <= halt_q | mem_sys_q;
        end
    end
`else
    assign halt_q = 1'b0;
`endif

    assign bus.stall          = stall_c;
    assign bus.ex_branch      = ex_ctrl.branch;
    assign bus.ex_mem_read    = ex_ctrl.mem_read;
    assign bus.ex_mem_to_reg  = ex_ctrl.mem_to_reg;
    assign bus.ex_mem_write   = ex_ctrl.mem_write;
    assign bus.ex_alu_src     = ex_ctrl.alu_src;
    assign bus.ex_reg_write   = ex_ctrl.reg_write;
    assign bus.ex_jal         = ex_ctrl.jal;
    assign bus.ex_jalr        = ex_ctrl.jalr;
    assign bus.ex_alu_op      = ALUOPW'(ex_ctrl.alu_op);
    assign bus.ex_rd          = ex_rd_q;
    assign bus.mem_mem_read   = mem_mem_read_q;
    assign bus.mem_mem_write  = mem_mem_write_q;
    assign bus.mem_mem_to_reg = mem_mem_to_reg_q;
    assign bus.mem_reg_write  = mem_reg_write_q;
    assign bus.mem_rd         = mem_rd_q;
    assign bus.wb_mem_to_reg  = wb_mem_to_reg_q;
    assign bus.wb_reg_write   = wb_reg_write_q;
    assign bus.wb_rd          = wb_rd_q;
    assign bus.halt           = halt_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Scoreboard bench for pipe_ctrl_unit: expected stage contents queued at issue, checked as they emerge.
module tb_pipe_ctrl_unit;

    // Expected stage content: {sys,branch,mem_read,mem_to_reg,mem_write,alu_src,reg_write,jal,jalr,alu_op[1:0]} + rd
    typedef struct packed {
        logic [10:0] v;
        logic [4:0]  rd;
    } ent_t;

    localparam logic [4:0] R_OP  = 5'b01100, I_OP  = 5'b00100, LD_OP = 5'b00000;
    localparam logic [4:0] ST_OP = 5'b01000, BR_OP = 5'b11000, JAL_OP = 5'b11011;
    localparam logic [4:0] JR_OP = 5'b11001, LUI_OP = 5'b01101, AUI_OP = 5'b00101;
    localparam logic [4:0] SYS_OP = 5'b11100, BAD_OP = 5'b01011;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_ctrl_unit_if #(.OPW(5), .RAW(5), .ALUOPW(2)) bus ();

    pipe_ctrl_unit #(.OPW(5), .RAW(5), .ALUOPW(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   n_vec  = 0;
    int   n_miss = 0;
    ent_t ex_q[$];
    ent_t mem_q[$];
    ent_t wb_q[$];
    ent_t cur_ex;
    logic halt_m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [10:0] exp_decode(input logic [4:0] op, input logic [4:0] rd);
        logic br, mr, m2r, mw, as, rw, j, jr, sy;
        logic [1:0] aop;
        {br, mr, m2r, mw, as, rw, j, jr, sy} = '0;
        aop = 2'b00;
        case (op)
            R_OP:           begin rw = 1; aop = 2'b10; end
            I_OP:           begin as = 1; rw = 1; aop = 2'b11; end
            LD_OP:          begin mr = 1; m2r = 1; as = 1; rw = 1; end
            ST_OP:          begin mw = 1; as = 1; end
            BR_OP:          begin br = 1; aop = 2'b01; end
            JAL_OP:         begin j = 1; rw = 1; end
            JR_OP:          begin jr = 1; as = 1; rw = 1; end
            LUI_OP, AUI_OP: begin as = 1; rw = 1; end
`ifdef CTRL_HALT_EN
            SYS_OP:         sy = 1;
`endif
            default: ;
        endcase
        if (rd == 5'd0) rw = 0;
        return {sy, br, mr, m2r, mw, as, rw, j, jr, aop};
    endfunction

    task automatic check_stages();
        ent_t e, m, w;
        if (ex_q.size() == 0 || mem_q.size() == 0 || wb_q.size() == 0) begin
            check("sb_underflow", 32'd0, 32'd1);
            return;
        end
        w = wb_q.pop_front();
        m = mem_q.pop_front();
        e = ex_q.pop_front();
        check("ex_ctrl", 32'({bus.ex_branch, bus.ex_mem_read, bus.ex_mem_to_reg, bus.ex_mem_write,
                              bus.ex_alu_src, bus.ex_reg_write, bus.ex_jal, bus.ex_jalr, bus.ex_alu_op}),
              32'(e.v[9:0]));
        check("ex_rd", 32'(bus.ex_rd), 32'(e.rd));
        check("mem_ctrl", 32'({bus.mem_mem_read, bus.mem_mem_write, bus.mem_mem_to_reg, bus.mem_reg_write}),
              32'({m.v[8], m.v[6], m.v[7], m.v[4]}));
        check("mem_rd", 32'(bus.mem_rd), 32'(m.rd));
        check("wb_ctrl", 32'({bus.wb_mem_to_reg, bus.wb_reg_write}), 32'({w.v[7], w.v[4]}));
        check("wb_rd", 32'(bus.wb_rd), 32'(w.rd));
        halt_m = halt_m | w.v[10];
        check("halt", 32'(bus.halt), 32'(halt_m));
        wb_q.push_back(m);
        mem_q.push_back(e);
        cur_ex = e;
    endtask

    // Called one step after a rising edge; returns one step after the next one
    task automatic step(input logic valid, input logic [4:0] op, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [4:0] rd, input logic flush);
        logic es, bub;
        ent_t nx;
        bus.id_valid = valid; bus.id_opcode = op; bus.id_rs1 = rs1;
        bus.id_rs2 = rs2; bus.id_rd = rd; bus.ex_flush = flush;
        #1;
        es = valid & cur_ex.v[8] & (cur_ex.rd != 5'd0) & ((cur_ex.rd == rs1) | (cur_ex.rd == rs2));
        check("stall", 32'(bus.stall), 32'(es));
        bub = flush | es | ~valid | halt_m;
        nx.v  = bub ? 11'd0 : exp_decode(op, rd);
        nx.rd = bub ? 5'd0 : rd;
        ex_q.push_back(nx);
        @(posedge clk);
        #1;
        check_stages();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, LD_OP, 5'd0, 5'd0, 5'd0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.id_valid = 1'b0; bus.id_opcode = '0; bus.id_rs1 = '0;
        bus.id_rs2 = '0; bus.id_rd = '0; bus.ex_flush = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        ex_q.delete(); mem_q.delete(); wb_q.delete();
        cur_ex = '0;
        halt_m = 1'b0;
        mem_q.push_back('0);
        wb_q.push_back('0);
        check("rst_ex", 32'({bus.ex_branch, bus.ex_mem_read, bus.ex_mem_to_reg, bus.ex_mem_write,
                             bus.ex_alu_src, bus.ex_reg_write, bus.ex_jal, bus.ex_jalr, bus.ex_alu_op, bus.ex_rd}), 0);
        check("rst_mem", 32'({bus.mem_mem_read, bus.mem_mem_write, bus.mem_mem_to_reg, bus.mem_reg_write, bus.mem_rd}), 0);
        check("rst_wb", 32'({bus.wb_mem_to_reg, bus.wb_reg_write, bus.wb_rd}), 0);
        check("rst_halt", 32'(bus.halt), 0);
        check("rst_stall", 32'(bus.stall), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [4:0] ops[10];
        ops = '{R_OP, I_OP, LD_OP, ST_OP, BR_OP, JAL_OP, JR_OP, LUI_OP, AUI_OP, BAD_OP};
        do_reset();

        // LW rd=5 flows to WB
        step(1'b1, LD_OP, 5'd1, 5'd0, 5'd5, 1'b0);
        check("lw_ex_bits", 32'({bus.ex_mem_read, bus.ex_mem_to_reg, bus.ex_alu_src, bus.ex_reg_write}), 32'hF);
        idle(2);
        check("lw_wb", 32'({bus.wb_reg_write, bus.wb_rd}), 32'({1'b1, 5'd5}));
        idle(1);

        // Load-use on rs2, ADD re-presented after the stall
        step(1'b1, LD_OP, 5'd2, 5'd0, 5'd5, 1'b0);
        step(1'b1, R_OP, 5'd3, 5'd5, 5'd6, 1'b0);
        step(1'b1, R_OP, 5'd3, 5'd5, 5'd6, 1'b0);
        idle(3);

        // Load to x0 never stalls and never writes
        step(1'b1, LD_OP, 5'd2, 5'd0, 5'd0, 1'b0);
        step(1'b1, R_OP, 5'd0, 5'd4, 5'd7, 1'b0);
        idle(3);

        // Branch in EX flushes a JAL in ID
        step(1'b1, BR_OP, 5'd1, 5'd2, 5'd0, 1'b0);
        step(1'b1, JAL_OP, 5'd0, 5'd0, 5'd1, 1'b1);
        idle(3);

        // JAL in EX resolves with flush; it still advances to MEM and WB
        step(1'b1, JAL_OP, 5'd0, 5'd0, 5'd1, 1'b0);
        step(1'b1, I_OP, 5'd2, 5'd0, 5'd3, 1'b1);
        check("jal_mem", 32'({bus.mem_reg_write, bus.mem_rd}), 32'({1'b1, 5'd1}));
        idle(3);

        // Flush and load-use together
        step(1'b1, LD_OP, 5'd2, 5'd0, 5'd5, 1'b0);
        step(1'b1, R_OP, 5'd5, 5'd1, 5'd6, 1'b1);
        step(1'b1, I_OP, 5'd5, 5'd0, 5'd8, 1'b0);
        idle(3);

        // Remaining opcodes, rd==0, illegal opcode, invalid slot
        step(1'b1, ST_OP, 5'd1, 5'd2, 5'd9, 1'b0);
        step(1'b1, LUI_OP, 5'd0, 5'd0, 5'd10, 1'b0);
        step(1'b1, AUI_OP, 5'd0, 5'd0, 5'd11, 1'b0);
        step(1'b1, JR_OP, 5'd1, 5'd0, 5'd12, 1'b0);
        step(1'b1, R_OP, 5'd1, 5'd2, 5'd0, 1'b0);
        step(1'b1, BAD_OP, 5'd1, 5'd2, 5'd13, 1'b0);
        step(1'b0, LD_OP, 5'd1, 5'd2, 5'd14, 1'b0);
        idle(3);

        // Random traffic on a small register set to provoke hazards
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 7) != 0), ops[$urandom_range(0, 9)],
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 ($urandom_range(0, 7) == 0));
        end
        idle(3);

        // Flushed SYSTEM must not halt
        step(1'b1, BR_OP, 5'd1, 5'd2, 5'd0, 1'b0);
        step(1'b1, SYS_OP, 5'd0, 5'd0, 5'd0, 1'b1);
        idle(4);

        // SYSTEM: halt (if enabled) three edges later, sticky, blocks later decode
        step(1'b1, SYS_OP, 5'd0, 5'd0, 5'd0, 1'b0);
        idle(2);
        step(1'b1, R_OP, 5'd1, 5'd2, 5'd3, 1'b0);
        step(1'b1, R_OP, 5'd1, 5'd2, 5'd3, 1'b0);
        idle(4);

        // Mid-operation reset drops in-flight instructions and clears halt
        step(1'b1, LD_OP, 5'd1, 5'd0, 5'd5, 1'b0);
        step(1'b1, JAL_OP, 5'd0, 5'd0, 5'd2, 1'b0);
        do_reset();
        step(1'b1, R_OP, 5'd1, 5'd2, 5'd3, 1'b0);
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
